pushit_mux: RTL and testbench

Parametrised multi-channel event serializer. It latches a counter value and a shared timestamp when any of NCH channel strobes fires, arbitrates between pending channels, and pushes each event as a fixed-length byte record into a byte-wide sink that exposes a `busy` flag (USB FIFO front end). It replaces the fixed two-source trigger/cycle pusher with configurable channel count and field widths, per-channel overrun detection, and an optional checksum byte.

---
 rtl/pushit_mux.sv | 97 +++++++++
 tb/tb_pushit_mux.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pushit_mux.sv
// pushit_mux: multi-channel event serializer into a byte-wide busy-gated sink.
// Define PUSHIT_CSUM_EN to append an XOR checksum byte to every record.
module pushit_mux #(
  parameter int NCH = 2,
  parameter int NUMW = 18,
  parameter int TIMEW = 36
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      ready,
  input  logic [NCH*NUMW-1:0] num,
  input  logic [TIMEW-1:0]    timenum,
  input  logic                busy,
  output logic [7:0]          data,
  output logic                write,
  output logic [NCH-1:0]      overrun
);
  localparam int NB = (NUMW + 7) / 8;
  localparam int TB = (TIMEW + 7) / 8;
  localparam int RB = 1 + NB + TB;
`ifdef PUSHIT_CSUM_EN
  localparam int LB = RB + 1;
`else
  localparam int LB = RB;
`endif
  localparam int CW = $clog2(LB + 1);
  localparam int SW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] clr;
  logic [NUMW-1:0] hnum [NCH];
  logic [TIMEW-1:0] htime [NCH];
  logic [8*LB-1:0] sr;
  logic [8*LB-1:0] load;
  logic [8*RB-1:0] rec;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sidx;
  logic grant;
  always_comb begin
    sidx = '0;
    for (int i = NCH - 1; i >= 0; i--) if (pend[i]) sidx = SW'(i);
  end
  assign grant = (state == IDLE) && |pend;
  assign clr = grant ? (NCH'(1) << sidx) : '0;
  assign rec = {4'hA, 4'(sidx), (8*NB)'(hnum[sidx]), (8*TB)'(htime[sidx])};
`ifdef PUSHIT_CSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 0; i < RB; i++) csum = csum ^ rec[8*i +: 8];
  end
  assign load = {rec, csum};
`else
  assign load = rec;
`endif
  assign data = sr[8*LB-1 -: 8];
  // A channel being granted this cycle frees its slot, so a same-cycle strobe is a fresh capture
  always_ff @(posedge clk)
    for (int c = 0; c < NCH; c++)
      if (ready[c] && (!pend[c] || clr[c])) begin
        hnum[c] <= num[c*NUMW +: NUMW];
        htime[c] <= timenum;
      end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pend <= '0;
      overrun <= '0;
      sr <= '0;
      cnt <= '0;
      write <= 1'b0;
    end else begin
      pend <= ready | (pend & ~clr);
      overrun <= overrun | (ready & pend & ~clr);
      if (state == IDLE) begin
        if (grant) begin
          sr <= load;
          cnt <= CW'(LB);
          write <= !busy;
          state <= SEND;
        end
      end else if (state == SEND) begin
        if (write) begin
          sr <= sr << 8;
          cnt <= cnt - CW'(1);
          write <= 1'b0;
          state <= (cnt == CW'(1)) ? GAP : SEND;
        end else begin
          write <= !busy;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pushit_mux.sv
// tb_pushit_mux: directed vector table plus hand sequences for stall, overrun, reset and a parameter sweep.
module tb_pushit_mux;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy = 1'b0;
  logic [1:0] ready = '0;
  logic [35:0] num = '0;
  logic [35:0] timenum = '0;
  logic [7:0] data;
  logic write;
  logic [1:0] overrun;
  logic [3:0] ready2 = '0;
  logic [47:0] num2 = '0;
  logic [19:0] time2 = '0;
  logic [7:0] data2;
  logic write2;
  logic [3:0] overrun2;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic [7:0] q[$];
  logic [7:0] q2[$];
  int tq[$];
`ifdef PUSHIT_CSUM_EN
  localparam int LB = 10;
  localparam int LB2 = 7;
`else
  localparam int LB = 9;
  localparam int LB2 = 6;
`endif
  typedef struct {
    logic [1:0] rdy;
    logic [17:0] n0;
    logic [17:0] n1;
    logic [35:0] t;
    int n;
    logic [159:0] pk;
  } vec_t;
  vec_t v [3];

  pushit_mux dut (
    .clk(clk), .reset(reset), .ready(ready), .num(num), .timenum(timenum),
    .busy(busy), .data(data), .write(write), .overrun(overrun)
  );
  pushit_mux #(.NCH(4), .NUMW(12), .TIMEW(20)) dut2 (
    .clk(clk), .reset(reset), .ready(ready2), .num(num2), .timenum(time2),
    .busy(1'b0), .data(data2), .write(write2), .overrun(overrun2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (write) begin
      q.push_back(data);
      tq.push_back(cyc);
    end
    if (write2) q2.push_back(data2);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic wait_q(input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_bytes", 64'(q.size() >= n), 64'd1);
  endtask

  task automatic cmp_bytes(input string name, input logic [159:0] pk, input int n);
    check({name, "_count"}, 64'(q.size()), 64'(n));
    for (int j = 0; j < n && j < q.size(); j++) check({name, "_byte"}, 64'(q[j]), 64'(pk[8*(n-1-j) +: 8]));
  endtask

  task automatic pulse(input logic [1:0] r, input logic [17:0] n0, input logic [17:0] n1, input logic [35:0] t);
    ready = r;
    num = {n1, n0};
    timenum = t;
    tick();
    ready = '0;
    num = ~num;
    timenum = ~timenum;
  endtask

  initial begin
    int t0;
    logic ok;
`ifdef PUSHIT_CSUM_EN
    v[0] = '{2'b01, 18'h12345, 18'h00000, 36'h123456789, 10, 160'({72'hA00123450123456789, 8'h4E})};
    v[1] = '{2'b11, 18'h3ABCD, 18'h26789, 36'hFEDCBA987, 20,
             {72'hA003ABCD0FEDCBA987, 8'hC2, 72'hA10267890FEDCBA987, 8'h4A}};
    v[2] = '{2'b10, 18'h00000, 18'h3FFFF, 36'hFFFFFFFFF, 10, 160'({72'hA103FFFF0FFFFFFFFF, 8'hAD})};
`else
    v[0] = '{2'b01, 18'h12345, 18'h00000, 36'h123456789, 9, 160'(72'hA00123450123456789)};
    v[1] = '{2'b11, 18'h3ABCD, 18'h26789, 36'hFEDCBA987, 18,
             160'({72'hA003ABCD0FEDCBA987, 72'hA10267890FEDCBA987})};
    v[2] = '{2'b10, 18'h00000, 18'h3FFFF, 36'hFFFFFFFFF, 9, 160'(72'hA103FFFF0FFFFFFFFF)};
`endif
    tick(3);
    check("rst_write", 64'(write), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_write2", 64'(write2), 64'd0);
    reset = 1'b0;
    tick(2);

    ready2 = 4'b1000;
    num2 = {12'hABC, 36'h0};
    time2 = 20'h12345;
    tick();
    ready2 = '0;
    num2 = '1;
    time2 = '1;
    for (int k = 0; k < 100 && q2.size() < LB2; k++) tick();
    tick(10);
    check("sweep_count", 64'(q2.size()), 64'(LB2));
    begin
`ifdef PUSHIT_CSUM_EN
      logic [55:0] e2 = 56'hA30ABC01234572;
`else
      logic [55:0] e2 = 56'h00A30ABC012345;
`endif
      for (int j = 0; j < LB2 && j < q2.size(); j++) check("sweep_byte", 64'(q2[j]), 64'(e2[8*(LB2-1-j) +: 8]));
    end
    check("sweep_overrun", 64'(overrun2), 64'd0);

    for (int i = 0; i < 3; i++) begin
      q.delete();
      tq.delete();
      t0 = cyc;
      pulse(v[i].rdy, v[i].n0, v[i].n1, v[i].t);
      wait_q(v[i].n, 200);
      tick(10);
      cmp_bytes("vec", v[i].pk, v[i].n);
      if (tq.size() > 0) check("latency", 64'(tq[0] - t0), 64'd2);
      for (int j = 1; j < tq.size(); j++) check("spacing", 64'(tq[j] - tq[j-1]), (j % LB == 0) ? 64'd3 : 64'd2);
      check("vec_overrun", 64'(overrun), 64'd0);
    end

    q.delete();
    pulse(2'b01, 18'h12345, 18'h0, 36'h123456789);
    wait_q(3, 100);
    busy = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (write !== 1'b0 || data !== 8'h45) ok = 1'b0;
    end
    check("stall_hold", 64'(ok), 64'd1);
    check("stall_count", 64'(q.size()), 64'd3);
    busy = 1'b0;
    wait_q(LB, 100);
    tick(10);
    cmp_bytes("stall", v[0].pk, LB);

    q.delete();
    pulse(2'b01, 18'h00AAA, 18'h0, 36'h1);
    tick(2);
    pulse(2'b10, 18'h0, 18'h2BEEF, 36'h2);
    tick(2);
    pulse(2'b10, 18'h0, 18'h15555, 36'h3);
    wait_q(2 * LB, 200);
    tick(20);
`ifdef PUSHIT_CSUM_EN
    cmp_bytes("ovr", {72'hA0000AAA0000000001, 8'h01, 72'hA102BEEF0000000002, 8'hF0}, 2 * LB);
`else
    cmp_bytes("ovr", 160'({72'hA0000AAA0000000001, 72'hA102BEEF0000000002}), 2 * LB);
`endif
    check("ovr_flags", 64'(overrun), 64'd2);

    q.delete();
    pulse(2'b01, 18'h12345, 18'h0, 36'h123456789);
    tick(2);
    pulse(2'b10, 18'h0, 18'h11111, 36'h5);
    wait_q(2, 100);
    tick();
    check("rst_mid_b3", 64'(write), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_write", 64'(write), 64'd0);
    check("rst_mid_data", 64'(data), 64'd0);
    check("rst_mid_overrun", 64'(overrun), 64'd0);
    tick(40);
    check("rst_mid_nomore", 64'(q.size()), 64'd3);
    q.delete();
    pulse(2'b01, 18'h12345, 18'h0, 36'h123456789);
    wait_q(LB, 100);
    tick(20);
    cmp_bytes("after_rst", v[0].pk, LB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
